spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 134 +++++++++++++
 tb/tb_spi_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master, mode 0, one byte per handshake; bytes chain under one slave select
// until a byte flagged as last is sent.
module spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SS_SETUP = 2,
  parameter int unsigned SS_HOLD  = 2
) (
  input  logic       SysClk,
  input  logic       Reset,
  input  logic [7:0] txData,
  input  logic       txValid,
  input  logic       txLast,
  output logic       txReady,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       busy,
  output logic       SPI_SS,
  output logic       SPI_CLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(7);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic [6:0]       r_tx;
  logic [7:0]       r_rx;
  logic             r_last;
  logic             w_accept;
  logic             w_rise;
  logic             w_fall;
  logic             w_last_fall;

  // State register
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and per-cycle strobes for the datapath
  always_comb begin
    w_next      = r_state;
    w_accept    = txValid && txReady;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_last_fall = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SETUP;
      ST_SETUP: if (r_div == SETUP_LAST) w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (r_div == DIV_LAST) begin
          if (!SPI_CLK) begin
            w_rise = 1'b1;
          end else begin
            w_fall = 1'b1;
            if (r_bit == BIT_LAST) begin
              w_last_fall = 1'b1;
              w_next      = r_last ? ST_HOLD : ST_WAIT;
            end
          end
        end
      end
      ST_WAIT:  if (w_accept) w_next = ST_SHIFT;
      ST_HOLD:  if (r_div == HOLD_LAST) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath: counters, shift registers and registered outputs
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      r_div    <= '0;
      r_bit    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_last   <= 1'b0;
      txReady  <= 1'b0;
      rxData   <= 8'h00;
      rxValid  <= 1'b0;
      busy     <= 1'b0;
      SPI_SS   <= 1'b1;
      SPI_CLK  <= 1'b0;
      SPI_MOSI <= 1'b0;
    end else begin
      txReady <= (w_next == ST_IDLE) || (w_next == ST_WAIT);
      busy    <= (w_next != ST_IDLE);
      SPI_SS  <= (w_next == ST_IDLE);
      rxValid <= w_last_fall;

      // Phase counter restarts on every state change and every SPI_CLK edge
      if ((w_next != r_state) || w_rise || w_fall)
        r_div <= '0;
      else if ((r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD))
        r_div <= r_div + CNT_W'(1);

      if (w_rise)      SPI_CLK <= 1'b1;
      else if (w_fall) SPI_CLK <= 1'b0;

      if (w_rise) r_rx <= {r_rx[6:0], SPI_MISO};
      if (w_last_fall) rxData <= r_rx;

      // Byte capture at accept; MOSI steps on every falling edge but the last
      if (w_accept) begin
        r_tx     <= txData[6:0];
        r_last   <= txLast;
        r_bit    <= '0;
        SPI_MOSI <= txData[7];
      end else if (w_fall && !w_last_fall) begin
        r_tx     <= {r_tx[5:0], 1'b0};
        r_bit    <= r_bit + BIT_W'(1);
        SPI_MOSI <= r_tx[6];
      end else if (w_next == ST_IDLE) begin
        SPI_MOSI <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table-driven and random transactions against a
// transaction-level model, plus reset and fast-divider corner cases.
module tb_spi_master;

  localparam int DIV = 4;
  localparam int SU  = 2;
  localparam int HO  = 2;
  localparam int SU1 = 1;
  localparam int HO1 = 1;

  typedef struct {
    logic [7:0] tx;
    logic       last;
    int         gap;
    logic       poke;
    logic [7:0] miso;
    logic [7:0] exp_rx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, ss, sck, mosi, miso;
  logic       loopback, slave_bit;

  logic [7:0] tx_data1;
  logic       tx_valid1, tx_last1, tx_ready1;
  logic [7:0] rx_data1;
  logic       rx_valid1, busy1, ss1, sck1, mosi1, miso1;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : slave_bit;

  spi_master #(.CLK_DIV(DIV), .SS_SETUP(SU), .SS_HOLD(HO)) u_dut (
    .SysClk(clk), .Reset(rst_n), .txData(tx_data), .txValid(tx_valid), .txLast(tx_last),
    .txReady(tx_ready), .rxData(rx_data), .rxValid(rx_valid), .busy(busy),
    .SPI_SS(ss), .SPI_CLK(sck), .SPI_MOSI(mosi), .SPI_MISO(miso));

  spi_master #(.CLK_DIV(1), .SS_SETUP(SU1), .SS_HOLD(HO1)) u_dut1 (
    .SysClk(clk), .Reset(rst_n), .txData(tx_data1), .txValid(tx_valid1), .txLast(tx_last1),
    .txReady(tx_ready1), .rxData(rx_data1), .rxValid(rx_valid1), .busy(busy1),
    .SPI_SS(ss1), .SPI_CLK(sck1), .SPI_MOSI(mosi1), .SPI_MISO(miso1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor for the main instance
  bit         mon_bits[$];
  logic [7:0] mon_rx[$];
  int         mon_ss[$];
  int         mon_hi[$];
  int         mon_rxw[$];
  int         mon_rises = 0;
  logic       p_sck, p_ss, p_rxv;
  int         hi_run, ss_run, rxv_run;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_sck = 1'b0; p_ss = 1'b1; p_rxv = 1'b0;
      hi_run = 0; ss_run = 0; rxv_run = 0;
    end else begin
      if (sck && !p_sck) begin
        mon_bits.push_back(mosi);
        mon_rises++;
      end
      if (sck) hi_run++;
      else if (p_sck) begin mon_hi.push_back(hi_run); hi_run = 0; end
      if (rx_valid) begin
        if (!p_rxv) mon_rx.push_back(rx_data);
        rxv_run++;
      end else if (p_rxv) begin
        mon_rxw.push_back(rxv_run); rxv_run = 0;
      end
      if (!ss) ss_run++;
      else if (!p_ss) begin mon_ss.push_back(ss_run); ss_run = 0; end
      p_sck = sck; p_ss = ss; p_rxv = rx_valid;
    end
  end

  // Slave model: presents MSB at SS fall, next bit after each SCK fall
  logic [7:0] sl_bytes [0:15];
  logic [7:0] s_sh;
  logic       s_p_sck, s_p_ss;
  int         s_idx, s_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_p_sck = 1'b0; s_p_ss = 1'b1; s_idx = 0; s_cnt = 0; s_sh = 8'h00; slave_bit = 1'b0;
    end else begin
      if (!ss && s_p_ss) begin
        s_idx = 0; s_cnt = 0; s_sh = sl_bytes[0]; slave_bit = s_sh[7];
      end else if (!sck && s_p_sck) begin
        s_cnt++;
        if (s_cnt == 8) begin
          s_cnt = 0;
          if (s_idx < 15) s_idx++;
          s_sh = sl_bytes[s_idx];
        end else begin
          s_sh = {s_sh[6:0], 1'b0};
        end
        slave_bit = s_sh[7];
      end
      s_p_sck = sck; s_p_ss = ss;
    end
  end

  // Monitor for the CLK_DIV=1 instance
  bit         m1_sck[$];
  bit         m1_bits[$];
  logic [7:0] m1_rx[$];
  int         m1_ss[$];
  logic       p_ss1, p_sck1;
  int         run1;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ss1 = 1'b1; p_sck1 = 1'b0; run1 = 0;
    end else begin
      if (!ss1) begin m1_sck.push_back(sck1); run1++; end
      else if (!p_ss1) begin m1_ss.push_back(run1); run1 = 0; end
      if (sck1 && !p_sck1) m1_bits.push_back(mosi1);
      if (rx_valid1) m1_rx.push_back(rx_data1);
      p_ss1 = ss1; p_sck1 = sck1;
    end
  end

  vec_t cur[$];
  vec_t tbl[$];

  // Drive one transaction from cur[] and compare against the model
  task automatic run_txn();
    int n, bb, rb, sb, hb, wb, exp_ss, to, bad;
    logic stall_bad;
    logic [7:0] b;
    n  = cur.size();
    bb = mon_bits.size(); rb = mon_rx.size(); sb = mon_ss.size();
    hb = mon_hi.size();   wb = mon_rxw.size();
    for (int i = 0; i < n; i++) sl_bytes[i] = cur[i].miso;
    exp_ss = SU + HO + n * 16 * DIV;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i > 0) exp_ss += 1 + cur[i].gap;
      to = 0;
      while (!tx_ready && to < 5000) begin @(negedge clk); to++; end
      if (!tx_ready) begin chk("ready_timeout", 0, 1); return; end
      if (cur[i].gap > 0) begin
        stall_bad = 1'b0;
        repeat (cur[i].gap) begin
          @(negedge clk);
          if (ss !== 1'b0 || sck !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b1) stall_bad = 1'b1;
        end
        chk("wait_stall_bad", int'(stall_bad), 0);
      end
      tx_data = cur[i].tx; tx_last = cur[i].last; tx_valid = 1'b1;
      @(posedge clk); #1;
      if (i + 1 < n && cur[i+1].gap == 0) begin
        tx_data = cur[i+1].tx; tx_last = cur[i+1].last;
      end else begin
        tx_valid = 1'b0; tx_data = 8'($urandom); tx_last = 1'($urandom);
      end
      if (cur[i].poke && !tx_valid) begin
        repeat (5) @(negedge clk);
        tx_valid = 1'b1; tx_data = ~cur[i].tx; tx_last = ~cur[i].last;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    end
    to = 0;
    while (mon_ss.size() == sb && to < 5000) begin @(negedge clk); to++; end
    chk("ss_low_windows", mon_ss.size() - sb, 1);
    if (mon_ss.size() > sb) chk("ss_low_cycles", mon_ss[sb], exp_ss);
    chk("sck_rises", mon_bits.size() - bb, 8 * n);
    chk("rx_pulses", mon_rx.size() - rb, n);
    for (int i = 0; i < n; i++) begin
      if (mon_bits.size() >= bb + 8 * (i + 1)) begin
        b = 8'h00;
        for (int k = 0; k < 8; k++) b = {b[6:0], 1'(mon_bits[bb + 8*i + k])};
        chk("mosi_byte", int'(b), int'(cur[i].tx));
      end
      if (mon_rx.size() > rb + i) chk("rx_byte", int'(mon_rx[rb + i]), int'(cur[i].exp_rx));
    end
    bad = 0;
    for (int j = hb; j < mon_hi.size(); j++) if (mon_hi[j] != DIV) bad++;
    chk("sck_high_width_bad", bad, 0);
    bad = 0;
    for (int j = wb; j < mon_rxw.size(); j++) if (mon_rxw[j] != 1) bad++;
    chk("rxvalid_width_bad", bad, 0);
    chk("end_busy", int'(busy), 0);
    chk("end_ready", int'(tx_ready), 1);
    chk("end_ss", int'(ss), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rb, to, g;
    logic [7:0] m;
    rst_n = 1'b0; loopback = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
    tx_data1 = 8'h00; tx_valid1 = 1'b0; tx_last1 = 1'b0; miso1 = 1'b1;
    for (int i = 0; i < 16; i++) sl_bytes[i] = 8'h00;

    // Table of transactions; a record with last=1 closes a transaction
    tbl.push_back('{8'hA5, 1'b1, 0,   1'b0, 8'h3C, 8'h3C});
    tbl.push_back('{8'h5A, 1'b0, 0,   1'b0, 8'h96, 8'h96});
    tbl.push_back('{8'hC6, 1'b0, 0,   1'b0, 8'h0F, 8'h0F});
    tbl.push_back('{8'hA5, 1'b1, 0,   1'b0, 8'hF0, 8'hF0});
    tbl.push_back('{8'h01, 1'b0, 0,   1'b0, 8'h80, 8'h80});
    tbl.push_back('{8'hE7, 1'b1, 100, 1'b0, 8'h55, 8'h55});
    tbl.push_back('{8'h00, 1'b1, 0,   1'b1, 8'hFF, 8'hFF});
    tbl.push_back('{8'hFF, 1'b0, 0,   1'b1, 8'h00, 8'h00});
    tbl.push_back('{8'h81, 1'b1, 3,   1'b0, 8'h7E, 8'h7E});

    // Reset values, then ready on the first edge after release
    #12;
    chk("rst_ss", int'(ss), 1);        chk("rst_sck", int'(sck), 0);
    chk("rst_mosi", int'(mosi), 0);    chk("rst_ready", int'(tx_ready), 0);
    chk("rst_rxvalid", int'(rx_valid), 0); chk("rst_rxdata", int'(rx_data), 0);
    chk("rst_busy", int'(busy), 0);    chk("rst_ss1", int'(ss1), 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_first_edge", int'(tx_ready), 1);

    // Single byte with MISO looped back from MOSI
    loopback = 1'b1;
    cur.delete();
    cur.push_back('{8'hA5, 1'b1, 0, 1'b0, 8'h00, 8'hA5});
    run_txn();
    loopback = 1'b0;

    // Table-driven transactions
    cur.delete();
    for (int i = 0; i < tbl.size(); i++) begin
      cur.push_back(tbl[i]);
      if (tbl[i].last) begin run_txn(); cur.delete(); end
    end

    // Reset in the middle of a byte
    @(negedge clk);
    to = 0;
    while (!tx_ready && to < 1000) begin @(negedge clk); to++; end
    sl_bytes[0] = 8'hC3;
    tx_data = 8'h3C; tx_last = 1'b1; tx_valid = 1'b1;
    @(posedge clk); #1; tx_valid = 1'b0;
    rb = mon_rx.size();
    n = mon_rises;
    to = 0;
    while (mon_rises < n + 3 && to < 2000) begin @(negedge clk); to++; end
    chk("pre_reset_rises", mon_rises - n, 3);
    chk("pre_reset_rxdata", int'(rx_data), 8'h7E);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("mid_rst_ss", int'(ss), 1);         chk("mid_rst_sck", int'(sck), 0);
    chk("mid_rst_mosi", int'(mosi), 0);     chk("mid_rst_rxdata", int'(rx_data), 0);
    chk("mid_rst_ready", int'(tx_ready), 0); chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rxvalid", int'(rx_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", int'(tx_ready), 1);
    repeat (150) @(negedge clk);
    chk("post_rst_no_rx", mon_rx.size() - rb, 0);
    chk("post_rst_ss", int'(ss), 1);
    chk("post_rst_busy", int'(busy), 0);

    // Random transactions
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 4);
      cur.delete();
      for (int i = 0; i < n; i++) begin
        m = 8'($urandom);
        g = (i == 0 || $urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
        cur.push_back('{8'($urandom), (i == n - 1), g, ($urandom_range(0, 3) == 0), m, m});
      end
      run_txn();
    end

    // CLK_DIV=1 with MISO tied high
    @(negedge clk);
    to = 0;
    while (!tx_ready1 && to < 100) begin @(negedge clk); to++; end
    tx_data1 = 8'h96; tx_last1 = 1'b1; tx_valid1 = 1'b1;
    @(posedge clk); #1; tx_valid1 = 1'b0; tx_data1 = 8'h00;
    to = 0;
    while (m1_ss.size() == 0 && to < 1000) begin @(negedge clk); to++; end
    chk("div1_windows", m1_ss.size(), 1);
    chk("div1_ss_cycles", m1_sck.size(), SU1 + 16 + HO1);
    n = 0;
    for (int k = 0; k < m1_sck.size(); k++)
      if (int'(m1_sck[k]) != ((k >= SU1 && k < SU1 + 16) ? ((k - SU1) % 2) : 0)) n++;
    chk("div1_sck_pattern_bad", n, 0);
    chk("div1_rx_pulses", m1_rx.size(), 1);
    if (m1_rx.size() > 0) chk("div1_rxdata", int'(m1_rx[0]), 8'hFF);
    m = 8'h00;
    for (int k = 0; k < m1_bits.size() && k < 8; k++) m = {m[6:0], 1'(m1_bits[k])};
    chk("div1_mosi_bits", m1_bits.size(), 8);
    chk("div1_mosi_byte", int'(m), 8'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
